// File: rtl/lane_collision_monitor.sv
// lane_collision_monitor: samples one lane row for a frog collision and runs the
// hit / invulnerable flash / respawn / game-over life sequence.
module lane_collision_monitor #(
   parameter int WIDTH        = 16,
   parameter int LIVES        = 3,
   parameter int FLASH_CYCLES = 64,
   parameter int BLINK_DIV    = 8,
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1,
   localparam int FW = $clog2(FLASH_CYCLES),
   localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [WIDTH-1:0] i_lane_pixels,
   input  logic             i_frog_in_lane,
   input  logic [CW-1:0]    i_frog_col,
   input  logic             i_restart,
   output logic             o_hit,
   output logic             o_respawn,
   output logic             o_blink,
   output logic             o_game_over,
   output logic [2:0]       o_lives
);
   typedef enum logic [1:0] {ALIVE, HIT_FLASH, GAME_OVER} state_t;
   state_t        r_state, w_state_n;
   logic          r_coll, r_hit, r_respawn, r_blink;
   logic          w_hit_n, w_respawn_n, w_blink_n, w_coll;
   logic [2:0]    r_lives, w_lives_n;
   logic [FW-1:0] r_flash, w_flash_n;
   logic [BW-1:0] r_bcnt, w_bcnt_n;
   logic [WIDTH-1:0] w_shift;
   // Shifting instead of indexing yields 0 for an out-of-range column, never X.
   assign w_shift = i_lane_pixels >> i_frog_col;
   assign w_coll  = i_frog_in_lane & w_shift[0];
   always_comb begin
      w_state_n   = r_state;
      w_lives_n   = r_lives;
      w_flash_n   = r_flash;
      w_bcnt_n    = r_bcnt;
      w_blink_n   = r_blink;
      w_hit_n     = 1'b0;
      w_respawn_n = 1'b0;
      if (i_restart) begin
         w_state_n   = ALIVE;
         w_lives_n   = 3'(LIVES);
         w_flash_n   = '0;
         w_bcnt_n    = '0;
         w_blink_n   = 1'b0;
         w_respawn_n = 1'b1;
      end else begin
         case (r_state)
            ALIVE: if (r_coll) begin
               w_hit_n   = 1'b1;
               w_lives_n = (r_lives != 3'd0) ? r_lives - 3'd1 : 3'd0;
               w_state_n = (r_lives > 3'd1) ? HIT_FLASH : GAME_OVER;
               w_flash_n = FW'(FLASH_CYCLES - 1);
               w_bcnt_n  = '0;
               w_blink_n = r_lives > 3'd1;
            end
            HIT_FLASH: if (r_flash == '0) begin
               w_state_n   = ALIVE;
               w_respawn_n = 1'b1;
               w_blink_n   = 1'b0;
               w_bcnt_n    = '0;
            end else begin
               w_flash_n = r_flash - 1'b1;
               w_bcnt_n  = (r_bcnt == BW'(BLINK_DIV - 1)) ? '0 : r_bcnt + 1'b1;
               w_blink_n = (r_bcnt == BW'(BLINK_DIV - 1)) ? ~r_blink : r_blink;
            end
            GAME_OVER: w_blink_n = 1'b0;
            default:   w_state_n = ALIVE;
         endcase
      end
   end
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state   <= ALIVE;
         r_lives   <= 3'(LIVES);
         r_coll    <= 1'b0;
         r_hit     <= 1'b0;
         r_respawn <= 1'b0;
         r_blink   <= 1'b0;
         r_flash   <= '0;
         r_bcnt    <= '0;
      end else begin
         r_state   <= w_state_n;
         r_lives   <= w_lives_n;
         r_coll    <= w_coll & ~i_restart;
         r_hit     <= w_hit_n;
         r_respawn <= w_respawn_n;
         r_blink   <= w_blink_n;
         r_flash   <= w_flash_n;
         r_bcnt    <= w_bcnt_n;
      end
   end
   assign o_hit       = r_hit;
   assign o_respawn   = r_respawn;
   assign o_blink     = r_blink;
   assign o_game_over = r_state == GAME_OVER;
   assign o_lives     = r_lives;
endmodule

// File: tb/tb_lane_collision_monitor.sv
// tb_lane_collision_monitor: scoreboard bench; a window/lives model predicts each cycle's outputs.
module tb_lane_collision_monitor;
   localparam int LV = 3, FC = 8, BD = 2;
   typedef struct {logic hit, respawn, blink, over; logic [2:0] lives;} exp_t;
   logic        clk = 1'b0, rst_n = 1'b0, restart = 1'b0, frog_in_lane = 1'b0;
   logic [15:0] lane_pixels = '0;
   logic [3:0]  frog_col = '0;
   logic        hit, respawn, blink, game_over;
   logic [2:0]  lives;
   exp_t        q[$];
   int          n_checks = 0, n_fail = 0;
   int          m_edge = 0, m_ws = 0, m_lives = LV;
   bit          m_over = 0, m_flash = 0, m_prev = 0;
   lane_collision_monitor #(.WIDTH(16), .LIVES(LV), .FLASH_CYCLES(FC), .BLINK_DIV(BD)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_lane_pixels(lane_pixels), .i_frog_in_lane(frog_in_lane),
      .i_frog_col(frog_col), .i_restart(restart), .o_hit(hit), .o_respawn(respawn),
      .o_blink(blink), .o_game_over(game_over), .o_lives(lives));
   always #5 clk = ~clk;
   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask
   always @(posedge clk) begin
      #2;
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         chk("hit", int'(hit), int'(e.hit));
         chk("respawn", int'(respawn), int'(e.respawn));
         chk("blink", int'(blink), int'(e.blink));
         chk("game_over", int'(game_over), int'(e.over));
         chk("lives", int'(lives), int'(e.lives));
      end
   end
   task automatic model_reset();
      m_lives = LV; m_over = 0; m_flash = 0; m_prev = 0;
   endtask
   // Called at a falling edge: drive inputs, predict the next rising edge, wait one cycle.
   task automatic step(input bit rs, input logic [15:0] px, input bit inl, input logic [3:0] col);
      exp_t e;
      bit   cond;
      restart = rs; lane_pixels = px; frog_in_lane = inl; frog_col = col;
      cond = inl && px[col];
      e.hit = 0; e.respawn = 0;
      if (rs) begin
         model_reset();
         e.respawn = 1;
      end else begin
         if (!m_over) begin
            if (m_flash) begin
               if (m_edge - m_ws == FC) begin m_flash = 0; e.respawn = 1; end
            end else if (m_prev) begin
               e.hit = 1;
               m_lives--;
               if (m_lives == 0) m_over = 1;
               else begin m_flash = 1; m_ws = m_edge; end
            end
         end
         m_prev = cond;
      end
      e.blink = m_flash && (((m_edge - m_ws) / BD) % 2 == 0);
      e.over  = m_over;
      e.lives = 3'(m_lives);
      q.push_back(e);
      m_edge++;
      @(negedge clk);
   endtask
   task automatic check_reset_vals(input string tag);
      chk({tag, "_hit"}, int'(hit), 0);
      chk({tag, "_respawn"}, int'(respawn), 0);
      chk({tag, "_blink"}, int'(blink), 0);
      chk({tag, "_game_over"}, int'(game_over), 0);
      chk({tag, "_lives"}, int'(lives), LV);
   endtask
   initial begin
      repeat (3) @(negedge clk);
      check_reset_vals("reset");
      rst_n = 1'b1;
      model_reset();
      repeat (20) step(0, 16'h0000, 1, 4'd5);
      step(0, 16'h0020, 1, 4'd5);
      repeat (12) step(0, 16'h0000, 1, 4'd5);
      repeat (40) step(0, 16'hFFFF, 1, 4'd5);
      step(1, 16'hFFFF, 1, 4'd5);
      repeat (4) step(0, 16'hFFFF, 1, 4'd5);
      repeat (12) step(0, 16'hFFFF, 0, 4'd5);
      repeat (6) step(0, 16'h8000, 1, 4'd15);
      repeat (12) step(0, 16'h0000, 1, 4'd15);
      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 39) == 0, 16'($urandom), $urandom_range(0, 1) == 1, 4'($urandom));
      step(1, 16'hFFFF, 1, 4'd3);
      repeat (3) step(0, 16'hFFFF, 1, 4'd3);
      #2 rst_n = 1'b0;
      #1 check_reset_vals("async");
      @(posedge clk);
      #2 chk("no_respawn_after_reset", int'(respawn), 0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      repeat (20) step(0, 16'($urandom), 1, 4'($urandom));
      chk("queue_drained", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
